vdc_vtiming_gen: RTL and testbench
==================================

Name: vdc_vtiming_gen

Overview:
Parametrised vertical timing generator for the VDC video pipeline. It is the successor to the fixed-width vertical signal block. It counts scanlines, character rows and the adjust lines of a frame, and produces the following:
- row/line position
- fetch strobes
- vertical display enable
- vsync, with interlace field offset
- cursor window
- a two-rate blink generator

It sits between the horizontal timing block, which supplies the line strobes, and the fetch/pixel units.

Parameters:
ROW_W, 8, width of row counter and of the vt/vd/vp registers
LINE_W, 5, width of line-in-row counter and of the ctv/cs/ce/vss registers
VSW_W, 4, width of the vsync-width register
BLINK_FRAMES, 16, frames per slow-blink half period; must be an even number ≥2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  pixel-clock enable; when low, all state holds
line_end  in  1  pulse, last cycle of a scanline
half_line  in  1  pulse, mid-scanline; never coincides with line_end
reg_vt  in  ROW_W  total rows minus 1
reg_va  in  LINE_W  adjust lines appended after the last row
reg_vd  in  ROW_W  displayed rows
reg_vp  in  ROW_W  row at which vsync begins
reg_vw  in  VSW_W  vsync width in lines; 0 means 2^VSW_W
reg_ctv  in  LINE_W  character height minus 1
reg_cs  in  LINE_W  cursor start line
reg_ce  in  LINE_W  cursor end line (inclusive)
reg_vss  in  LINE_W  vertical smooth scroll, first line of row 0
reg_im  in  2  interlace mode; bit 0 set = interlace
row  out  ROW_W  current row
line  out  LINE_W  current line in row
adjust  out  1  in adjust region
field  out  1  current field, 0 or 1
frame_start  out  1  one-cycle pulse, first line of a frame
row_start  out  1  one-cycle pulse, first line of a row
v_visible  out  1  row < reg_vd and not adjust
vsync  out  1  vertical sync
cursor  out  1  cursor window active on this line
blink_slow  out  1  toggles every BLINK_FRAMES frames
blink_fast  out  1  toggles every BLINK_FRAMES/2 frames

Behaviour:
- Reset values: all outputs 0; all counters 0; ctv_l = 0.
- All updates occur on a clk edge with enable=1. Outputs are registered and change the cycle after the qualifying strobe.
- ctv_l (latched char height) is loaded from reg_ctv at every row_start. Register changes therefore take effect at row granularity.

Counting on line_end:
- **ACTIVE state** (adjust=0):
  - If line != ctv_l: line += 1.
  - Else if row < reg_vt: row += 1, line = 0, row_start.
  - Else if reg_va != 0: enter ADJUST, adj count = 0, row held.
  - Else: frame wrap.
  - The comparison is row >= reg_vt, so a shrinking vt wraps at the next row end.
- **ADJUST state**: adj count += 1.
  - Wrap when adj count == reg_va - 1 + (field & im[0]). Odd fields get one extra line.
- **Frame wrap**:
  - row = 0; line = min(reg_vss, reg_ctv); adjust = 0.
  - frame_start and row_start pulse.
  - field toggles if im[0]=1, else field = 0.
  - Frame counter increments.

Frame counter and blink:
- The frame counter is modulo BLINK_FRAMES.
- blink_fast toggles at counts 0 and BLINK_FRAMES/2.
- blink_slow toggles at count 0.

v_visible:
- Updated with row/adjust: v_visible = !adjust && row < reg_vd.
- reg_vd = 0 means never visible.

cursor:
- cursor = reg_cs <= line <= reg_ce, evaluated on the new line value.
- If reg_cs > reg_ce, cursor is always 0.

vsync:
- Start event: the line_end that moves the position to (row = reg_vp, line = 0).
- In field 0, or with im[0]=0: at the start event, vs_cnt = reg_vw (or 2^VSW_W if 0). vs_cnt decrements on each following line_end.
- In field 1 with interlace: the start event arms a pending flag. The next half_line loads vs_cnt, and decrements occur on half_line. This gives a half-line offset.
- vsync = (vs_cnt != 0).
- A new start event while vs_cnt != 0 reloads the count.
- If reg_vp > reg_vt, vsync never fires.

Other rules:
- Reset mid-frame aborts everything, including pending and vsync, to the reset values above.
- A pulse arriving with enable=0 is ignored.

Test Plan:
1. vt=3, ctv=1, va=1, vd=2, vss=0, im=0; 10 line_ends → frame_start after line_end 9; row sequence 0,0,1,1,2,2,3,3 then adjust; v_visible high for first 4 lines only.
2. Same as 1 with vss=1 → row 0 lasts 1 line; frame = 8 lines; line=1 after wrap.
3. im=1, va=1 → field alternates; field-1 frame is 10 lines vs field-0 9 lines; vsync in field 1 rises on half_line, not line_end.
4. vp=2, vw=0, VSW_W=4 → vsync high exactly 16 line_ends; vw=3 → 3 lines.
5. cs=1, ce=1, ctv=2 → cursor high only on line 1 of each row; cs=2, ce=1 → cursor never.
6. BLINK_FRAMES=4, 8 frames → blink_fast toggles every 2 frames, blink_slow every 4; reset asserted mid-row → all outputs 0 next cycle; enable=0 with line_end → no change.

Source files
------------

// File: rtl/vdc_vtiming_gen.sv
// Vertical timing generator: counts scanlines, character rows and adjust
// lines per frame. Produces the row/line position, frame/row strobes,
// vertical display enable, interlace-aware vsync, the cursor window and
// two-rate blink.
module vdc_vtiming_gen #(
    parameter int ROW_W        = 8,
    parameter int LINE_W       = 5,
    parameter int VSW_W        = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              line_end,
    input  logic              half_line,
    input  logic [ROW_W-1:0]  reg_vt,
    input  logic [LINE_W-1:0] reg_va,
    input  logic [ROW_W-1:0]  reg_vd,
    input  logic [ROW_W-1:0]  reg_vp,
    input  logic [VSW_W-1:0]  reg_vw,
    input  logic [LINE_W-1:0] reg_ctv,
    input  logic [LINE_W-1:0] reg_cs,
    input  logic [LINE_W-1:0] reg_ce,
    input  logic [LINE_W-1:0] reg_vss,
    input  logic [1:0]        reg_im,
    output logic [ROW_W-1:0]  row,
    output logic [LINE_W-1:0] line,
    output logic              adjust,
    output logic              field,
    output logic              frame_start,
    output logic              row_start,
    output logic              v_visible,
    output logic              vsync,
    output logic              cursor,
    output logic              blink_slow,
    output logic              blink_fast
);

    localparam int FC_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [FC_W-1:0] FC_HALF = FC_W'(BLINK_FRAMES / 2);

    typedef enum logic {
        ST_ACTIVE,
        ST_ADJUST
    } vstate_t;

    vstate_t           state, state_n;
    logic [LINE_W-1:0] adj_cnt, adj_cnt_n;
    logic [LINE_W-1:0] ctv_l, ctv_l_n;
    logic [FC_W-1:0]   frame_cnt, frame_cnt_n;
    logic [VSW_W:0]    vs_cnt, vs_cnt_n;
    logic              vs_pend, vs_pend_n;
    logic              vs_half, vs_half_n;
    logic [ROW_W-1:0]  row_n;
    logic [LINE_W-1:0] line_n;
    logic              field_n;
    logic              wrap, new_row, vs_start;
    logic              slow_tgl, fast_tgl;
    logic              interlace;
    logic [LINE_W-1:0] adj_last;
    logic [LINE_W-1:0] wrap_line;
    logic [VSW_W:0]    vs_load;
    logic              unused_im;

    assign interlace = reg_im[0];
    assign unused_im = reg_im[1];
    // odd interlaced fields get one extra adjust line
    assign adj_last  = reg_va - 1'b1 + LINE_W'(field & interlace);
    assign wrap_line = (reg_vss < reg_ctv) ? reg_vss : reg_ctv;
    assign vs_load   = (reg_vw == '0) ? {1'b1, {VSW_W{1'b0}}} : {1'b0, reg_vw};

    // Next-state for position, field, frame count, blink and vsync counter
    always_comb begin
        state_n     = state;
        row_n       = row;
        line_n      = line;
        adj_cnt_n   = adj_cnt;
        ctv_l_n     = ctv_l;
        field_n     = field;
        frame_cnt_n = frame_cnt;
        wrap        = 1'b0;
        new_row     = 1'b0;
        slow_tgl    = 1'b0;
        fast_tgl    = 1'b0;
        vs_cnt_n    = vs_cnt;
        vs_pend_n   = vs_pend;
        vs_half_n   = vs_half;

        if (line_end) begin
            if (state == ST_ACTIVE) begin
                if (line != ctv_l) begin
                    line_n = line + 1'b1;
                end else if (row < reg_vt) begin
                    row_n   = row + 1'b1;
                    line_n  = '0;
                    new_row = 1'b1;
                end else if (reg_va != '0) begin
                    state_n   = ST_ADJUST;
                    adj_cnt_n = '0;
                end else begin
                    wrap = 1'b1;
                end
            end else if (adj_cnt == adj_last) begin
                wrap = 1'b1;
            end else begin
                adj_cnt_n = adj_cnt + 1'b1;
            end
        end

        if (wrap) begin
            row_n       = '0;
            line_n      = wrap_line;
            state_n     = ST_ACTIVE;
            adj_cnt_n   = '0;
            new_row     = 1'b1;
            field_n     = interlace ? ~field : 1'b0;
            frame_cnt_n = (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
            if (frame_cnt_n == '0) begin
                slow_tgl = 1'b1;
                fast_tgl = 1'b1;
            end else if (frame_cnt_n == FC_HALF) begin
                fast_tgl = 1'b1;
            end
        end

        if (new_row) begin
            ctv_l_n = reg_ctv;
        end

        // only row advances and wraps can land on line 0 of a new row
        vs_start = new_row && (row_n == reg_vp) && (line_n == '0);

        // field-1 interlaced sync is deferred to the next half_line and
        // then counts half_lines, giving the half-line field offset
        if (line_end) begin
            if (vs_start) begin
                if (field_n & interlace) begin
                    vs_pend_n = 1'b1;
                end else begin
                    vs_cnt_n  = vs_load;
                    vs_half_n = 1'b0;
                    vs_pend_n = 1'b0;
                end
            end else if (!vs_half && vs_cnt != '0) begin
                vs_cnt_n = vs_cnt - 1'b1;
            end
        end else if (half_line) begin
            if (vs_pend) begin
                vs_cnt_n  = vs_load;
                vs_half_n = 1'b1;
                vs_pend_n = 1'b0;
            end else if (vs_half && vs_cnt != '0) begin
                vs_cnt_n = vs_cnt - 1'b1;
            end
        end
    end

    // Register state and outputs; everything holds while enable is low
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_ACTIVE;
            row         <= '0;
            line        <= '0;
            adj_cnt     <= '0;
            ctv_l       <= '0;
            field       <= 1'b0;
            frame_cnt   <= '0;
            vs_cnt      <= '0;
            vs_pend     <= 1'b0;
            vs_half     <= 1'b0;
            adjust      <= 1'b0;
            frame_start <= 1'b0;
            row_start   <= 1'b0;
            v_visible   <= 1'b0;
            vsync       <= 1'b0;
            cursor      <= 1'b0;
            blink_slow  <= 1'b0;
            blink_fast  <= 1'b0;
        end else if (enable) begin
            state       <= state_n;
            row         <= row_n;
            line        <= line_n;
            adj_cnt     <= adj_cnt_n;
            ctv_l       <= ctv_l_n;
            field       <= field_n;
            frame_cnt   <= frame_cnt_n;
            vs_cnt      <= vs_cnt_n;
            vs_pend     <= vs_pend_n;
            vs_half     <= vs_half_n;
            adjust      <= (state_n == ST_ADJUST);
            frame_start <= wrap;
            row_start   <= new_row;
            vsync       <= (vs_cnt_n != '0);
            if (line_end) begin
                v_visible <= (state_n == ST_ACTIVE) && (row_n < reg_vd);
                cursor    <= (reg_cs <= line_n) && (line_n <= reg_ce);
            end
            if (slow_tgl) begin
                blink_slow <= ~blink_slow;
            end
            if (fast_tgl) begin
                blink_fast <= ~blink_fast;
            end
        end
    end

endmodule

// File: tb/tb_vdc_vtiming_gen.sv
// Bench for vdc_vtiming_gen: per-cycle scoreboard against a behavioural
// model, per-frame aggregate table, and hand sequences for reset, enable,
// interlaced vsync offset and blink rates.
module tb_vdc_vtiming_gen;

    localparam int ROW_W  = 8;
    localparam int LINE_W = 5;
    localparam int VSW_W  = 4;
    localparam int BF     = 4;

    typedef struct {
        int vt, va, vd, vp, vw, ctv, cs, ce, vss, im;
        int len2, len3, vis, cur, vs;
    } scen_t;

    typedef struct {
        logic [ROW_W-1:0]  row;
        logic [LINE_W-1:0] line;
        logic adjust, field, fs, rs, vis, vsync, cur, bs, bf;
    } snap_t;

    logic clk = 1'b0;
    logic reset = 1'b1, enable = 1'b0, line_end = 1'b0, half_line = 1'b0;
    logic [ROW_W-1:0]  reg_vt, reg_vd, reg_vp;
    logic [LINE_W-1:0] reg_va, reg_ctv, reg_cs, reg_ce, reg_vss;
    logic [VSW_W-1:0]  reg_vw;
    logic [1:0]        reg_im;
    logic [ROW_W-1:0]  row;
    logic [LINE_W-1:0] line;
    logic adjust, field, frame_start, row_start, v_visible, vsync, cursor;
    logic blink_slow, blink_fast;

    scen_t cfg = '{3, 1, 2, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    scen_t tbl[6];
    snap_t sb[$];
    int checks = 0;
    int errors = 0;

    // model state
    int m_row, m_line, m_adjc, m_ctvl, m_fcnt, m_vs;
    bit m_adj, m_field, m_pend, m_half, e_fs, e_rs, e_vis, e_cur, e_bs, e_bf;

    assign reg_vt  = ROW_W'(cfg.vt);
    assign reg_va  = LINE_W'(cfg.va);
    assign reg_vd  = ROW_W'(cfg.vd);
    assign reg_vp  = ROW_W'(cfg.vp);
    assign reg_vw  = VSW_W'(cfg.vw);
    assign reg_ctv = LINE_W'(cfg.ctv);
    assign reg_cs  = LINE_W'(cfg.cs);
    assign reg_ce  = LINE_W'(cfg.ce);
    assign reg_vss = LINE_W'(cfg.vss);
    assign reg_im  = 2'(cfg.im);

    vdc_vtiming_gen #(
        .ROW_W(ROW_W), .LINE_W(LINE_W), .VSW_W(VSW_W), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .line_end(line_end), .half_line(half_line),
        .reg_vt(reg_vt), .reg_va(reg_va), .reg_vd(reg_vd), .reg_vp(reg_vp),
        .reg_vw(reg_vw), .reg_ctv(reg_ctv), .reg_cs(reg_cs), .reg_ce(reg_ce),
        .reg_vss(reg_vss), .reg_im(reg_im),
        .row(row), .line(line), .adjust(adjust), .field(field),
        .frame_start(frame_start), .row_start(row_start),
        .v_visible(v_visible), .vsync(vsync), .cursor(cursor),
        .blink_slow(blink_slow), .blink_fast(blink_fast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic snap_t snap_now();
        snap_t s;
        s.row = row; s.line = line; s.adjust = adjust; s.field = field;
        s.fs = frame_start; s.rs = row_start; s.vis = v_visible;
        s.vsync = vsync; s.cur = cursor; s.bs = blink_slow; s.bf = blink_fast;
        return s;
    endfunction

    // Behavioural model; pushes the outputs expected after the next edge
    task automatic model_step(input bit rst, input bit en, input bit le, input bit hl);
        snap_t e;
        bit wrapped, newrow, vs_start, im0;
        int vs_load;
        im0 = (cfg.im & 1) != 0;
        if (rst) begin
            m_row = 0; m_line = 0; m_adjc = 0; m_ctvl = 0; m_fcnt = 0; m_vs = 0;
            m_adj = 0; m_field = 0; m_pend = 0; m_half = 0;
            e_fs = 0; e_rs = 0; e_vis = 0; e_cur = 0; e_bs = 0; e_bf = 0;
        end else if (en) begin
            wrapped = 0;
            newrow  = 0;
            if (le) begin
                if (!m_adj) begin
                    if (m_line != m_ctvl) m_line++;
                    else if (m_row < cfg.vt) begin m_row++; m_line = 0; newrow = 1; end
                    else if (cfg.va != 0) begin m_adj = 1; m_adjc = 0; end
                    else wrapped = 1;
                end else if (m_adjc == cfg.va - 1 + int'(m_field && im0)) begin
                    wrapped = 1;
                end else begin
                    m_adjc++;
                end
            end
            if (wrapped) begin
                m_row = 0;
                m_line = (cfg.vss < cfg.ctv) ? cfg.vss : cfg.ctv;
                m_adj = 0;
                newrow = 1;
                m_field = im0 ? !m_field : 1'b0;
                m_fcnt = (m_fcnt + 1) % BF;
                if (m_fcnt == 0) begin e_bs = !e_bs; e_bf = !e_bf; end
                else if (m_fcnt == BF / 2) e_bf = !e_bf;
            end
            if (newrow) m_ctvl = cfg.ctv;
            e_fs = wrapped;
            e_rs = newrow;
            vs_load = (cfg.vw == 0) ? (1 << VSW_W) : cfg.vw;
            vs_start = newrow && m_row == cfg.vp && m_line == 0;
            if (le) begin
                if (vs_start) begin
                    if (m_field && im0) m_pend = 1;
                    else begin m_vs = vs_load; m_half = 0; m_pend = 0; end
                end else if (!m_half && m_vs > 0) m_vs--;
                e_vis = !m_adj && m_row < cfg.vd;
                e_cur = cfg.cs <= m_line && m_line <= cfg.ce;
            end else if (hl) begin
                if (m_pend) begin m_vs = vs_load; m_half = 1; m_pend = 0; end
                else if (m_half && m_vs > 0) m_vs--;
            end
        end
        e.row = ROW_W'(m_row); e.line = LINE_W'(m_line); e.adjust = m_adj;
        e.field = m_field; e.fs = e_fs; e.rs = e_rs; e.vis = e_vis;
        e.vsync = (m_vs != 0); e.cur = e_cur; e.bs = e_bs; e.bf = e_bf;
        sb.push_back(e);
    endtask

    // One clock of stimulus: sample current outputs, then drive new inputs
    task automatic cyc(input bit rst, input bit en, input bit le, input bit hl, output snap_t s);
        @(negedge clk);
        s = snap_now();
        reset = rst; enable = en; line_end = le; half_line = hl;
        model_step(rst, en, le, hl);
    endtask

    // One scanline: pre = values held by the line, post = after its line_end
    task automatic do_line(output snap_t pre, output snap_t post);
        snap_t s;
        cyc(0, 1, 0, 1, s);
        cyc(0, 1, 0, 0, s);
        cyc(0, 1, 1, 0, pre);
        cyc(0, 1, 0, 0, post);
    endtask

    task automatic do_reset();
        snap_t s;
        cyc(1, 1, 0, 0, s);
        cyc(1, 1, 0, 0, s);
    endtask

    // Scoreboard checker, sampling away from the active edge
    initial begin
        snap_t a, e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = snap_now();
                chk("sb_row", a.row, e.row);
                chk("sb_line", a.line, e.line);
                chk("sb_adjust", a.adjust, e.adjust);
                chk("sb_field", a.field, e.field);
                chk("sb_frame_start", a.fs, e.fs);
                chk("sb_row_start", a.rs, e.rs);
                chk("sb_v_visible", a.vis, e.vis);
                chk("sb_vsync", a.vsync, e.vsync);
                chk("sb_cursor", a.cur, e.cur);
                chk("sb_blink_slow", a.bs, e.bs);
                chk("sb_blink_fast", a.bf, e.bf);
            end
        end
    end

    initial begin
        snap_t pre, post, s;
        int nfs, len2, len3, vis, cu, vs;

        //           vt va vd vp vw ctv cs ce vss im  len2 len3 vis cur vs
        tbl[0] = '{3, 1, 2, 2, 3, 1, 1, 1, 0, 0,   9,  9,  4,  5,  3};
        tbl[1] = '{3, 1, 2, 2, 3, 1, 1, 1, 1, 0,   8,  8,  3,  5,  3};
        tbl[2] = '{7, 2, 5, 2, 0, 3, 2, 1, 0, 0,  34, 34, 20,  0, 16};
        tbl[3] = '{3, 0, 4, 0, 1, 2, 1, 1, 0, 0,  12, 12, 12,  4,  1};
        tbl[4] = '{3, 1, 2, 2, 3, 1, 0, 0, 0, 1,  10,  9,  4,  4,  3};
        tbl[5] = '{3, 1, 0, 5, 3, 1, 3, 1, 0, 0,   9,  9,  0,  0,  0};

        // reset state
        do_reset();
        cyc(0, 1, 0, 0, s);
        chk("reset_state", {s.row, s.line, s.adjust, s.field, s.fs, s.rs,
                            s.vis, s.vsync, s.cur, s.bs, s.bf}, 0);

        // per-frame aggregates over the second and third frames
        for (int i = 0; i < 6; i++) begin
            cfg = tbl[i];
            do_reset();
            nfs = 0; len2 = 0; len3 = 0; vis = 0; cu = 0; vs = 0;
            for (int n = 0; n < 200 && nfs < 3; n++) begin
                do_line(pre, post);
                if (nfs == 1) begin
                    len2++;
                    vis += int'(pre.vis);
                    cu  += int'(pre.cur);
                    vs  += int'(pre.vsync);
                end else if (nfs == 2) begin
                    len3++;
                end
                if (post.fs) nfs++;
            end
            chk($sformatf("s%0d_frames", i), nfs, 3);
            chk($sformatf("s%0d_len2", i), len2, cfg.len2);
            chk($sformatf("s%0d_len3", i), len3, cfg.len3);
            chk($sformatf("s%0d_visible", i), vis, cfg.vis);
            chk($sformatf("s%0d_cursor", i), cu, cfg.cur);
            chk($sformatf("s%0d_vsync", i), vs, cfg.vs);
        end

        // enable low suppresses line_end and half_line
        cfg = tbl[0];
        do_reset();
        for (int n = 0; n < 3; n++) do_line(pre, post);
        chk("pos_row", post.row, 2);
        chk("pos_line", post.line, 0);
        cyc(0, 0, 1, 0, s);
        cyc(0, 0, 0, 1, s);
        cyc(0, 1, 0, 0, s);
        chk("en_off_row", s.row, 2);
        chk("en_off_line", s.line, 0);
        chk("en_off_vsync", s.vsync, 1);

        // reset mid-row with vsync active clears everything
        do_line(pre, post);
        do_line(pre, post);
        cyc(0, 1, 0, 1, s);
        cyc(1, 1, 0, 0, s);
        chk("pre_reset_vsync", s.vsync, 1);
        cyc(0, 1, 0, 0, s);
        chk("mid_reset_state", {s.row, s.line, s.adjust, s.field, s.fs, s.rs,
                                s.vis, s.vsync, s.cur, s.bs, s.bf}, 0);

        // field-1 vsync rises on half_line, not on the line_end
        cfg = tbl[4];
        do_reset();
        for (int n = 0; n < 12; n++) do_line(pre, post);
        chk("il_field", post.field, 1);
        chk("il_row", post.row, 2);
        chk("il_vsync_at_le", post.vsync, 0);
        cyc(0, 1, 0, 1, s);
        cyc(0, 1, 0, 0, s);
        chk("il_vsync_at_hl", s.vsync, 1);

        // blink rates with one-line frames
        cfg = '{0, 0, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            do_line(pre, post);
            chk($sformatf("blink_fs_%0d", k), post.fs, 1);
            chk($sformatf("blink_fast_%0d", k), post.bf, (k / 2) % 2);
            chk($sformatf("blink_slow_%0d", k), post.bs, (k / 4) % 2);
        end

        cyc(0, 1, 0, 0, s);
        @(posedge clk);
        #3;
        if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
